// File: rtl/fifo_track_monitor.sv
// Reads the overwrite FIFO one slot at a time, drops repeated slots, and delivers each new word once.
// Latency: 2 cycles from fifo_rd_en to m_valid. Backpressure: m_valid holds in OUT and no read is issued until m_ready.
module fifo_track_monitor #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 512
) (
  input  logic             rd_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic [31:0]      fifo_ptr,
  output logic [WIDTH-1:0] m_data,
  output logic [31:0]      m_ptr,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      word_count,
  output logic [31:0]      dup_count,
  output logic [31:0]      gap_count,
  output logic             busy
);

  localparam logic [31:0] LAST_SLOT = 32'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t      state, state_nxt;
  logic [31:0] last_ptr;
  logic [31:0] exp_ptr;
  logic        rd_ok;
  logic        is_dup;
  logic        handshake;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    rd_ok     = enable && !fifo_empty;
    exp_ptr   = (last_ptr == LAST_SLOT) ? 32'd0 : last_ptr + 32'd1;
    is_dup    = (fifo_ptr == last_ptr);
    handshake = m_valid && m_ready;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_ok) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = is_dup ? IDLE : OUT;
      OUT:     if (handshake) state_nxt = rd_ok ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign fifo_rd_en = (state == ISSUE);
  assign busy       = (state != IDLE);

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state      <= IDLE;
      last_ptr   <= LAST_SLOT;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_ptr      <= '0;
      word_count <= '0;
      dup_count  <= '0;
      gap_count  <= '0;
    end else begin
      state <= state_nxt;
      if (state == WAIT) begin
        if (is_dup) begin
          dup_count <= sat_inc(dup_count);
        end else begin
          if (fifo_ptr != exp_ptr) gap_count <= sat_inc(gap_count);
          m_data     <= fifo_data;
          m_ptr      <= fifo_ptr;
          last_ptr   <= fifo_ptr;
          word_count <= sat_inc(word_count);
          m_valid    <= 1'b1;
        end
      end else if (state == OUT && handshake) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_track_monitor.sv
// Directed bench: a FIFO stub answers read strobes from a response queue; a slot-level model predicts beats and counters.
module tb_fifo_track_monitor;
  localparam int DEPTH = 64;
  localparam int WIDTH = 512;

  logic             rd_clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b1;
  logic             fifo_empty = 1'b1;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_data = '0;
  logic [31:0]      fifo_ptr = '0;
  logic [WIDTH-1:0] m_data;
  logic [31:0]      m_ptr;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic [31:0]      word_count, dup_count, gap_count;
  logic             busy;

  always #5 rd_clk = ~rd_clk;

  fifo_track_monitor #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .rd_clk(rd_clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data), .fifo_ptr(fifo_ptr),
    .m_data(m_data), .m_ptr(m_ptr), .m_valid(m_valid), .m_ready(m_ready),
    .word_count(word_count), .dup_count(dup_count), .gap_count(gap_count), .busy(busy)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // FIFO responses to hand out, and beats the model expects to see
  logic [31:0]      rsp_ptr_q[$];
  logic [WIDTH-1:0] rsp_dat_q[$];
  logic [31:0]      beat_ptr_q[$];
  logic [WIDTH-1:0] beat_dat_q[$];

  int          mdl_last = DEPTH - 1;
  logic [31:0] mdl_word = 0, mdl_dup = 0, mdl_gap = 0;
  bit          mdl_vld = 0;

  bit               rd_q = 0, rst_q = 0, pend = 0, wait_now;
  logic [31:0]      pend_ptr;
  logic [WIDTH-1:0] pend_dat;
  int               cyc = 0, rd_cnt = 0, hs_cyc = 0;
  int               rd_cyc[$];
  bit               prev_vld = 0, prev_hs = 0;
  logic [31:0]      prev_ptr;
  logic [WIDTH-1:0] prev_dat;

  always @(negedge rd_clk) begin
    cyc++;
    if (rst_q) begin
      mdl_last = DEPTH - 1; mdl_word = 0; mdl_dup = 0; mdl_gap = 0; mdl_vld = 0;
      beat_ptr_q.delete(); beat_dat_q.delete();
    end else if (pend) begin
      if (int'(pend_ptr) == mdl_last) mdl_dup++;
      else begin
        if (int'(pend_ptr) != (mdl_last + 1) % DEPTH) mdl_gap++;
        mdl_word++;
        mdl_last = int'(pend_ptr);
        beat_ptr_q.push_back(pend_ptr);
        beat_dat_q.push_back(pend_dat);
        mdl_vld = 1;
      end
    end
    pend = 0;
    wait_now = rd_q && !rst_q;

    chk("word_count", word_count, mdl_word);
    chk("dup_count", dup_count, mdl_dup);
    chk("gap_count", gap_count, mdl_gap);
    chk("m_valid", m_valid, mdl_vld);
    chk("busy", busy, fifo_rd_en || wait_now || mdl_vld);
    chk("rd_en_back_to_back", fifo_rd_en && rd_q, 1'b0);
    chk("rd_en_while_valid", fifo_rd_en && m_valid, 1'b0);
    if (prev_vld && !prev_hs && m_valid && !rst_q) begin
      chk("m_ptr_stable", m_ptr, prev_ptr);
      chk("m_data_stable", m_data, prev_dat);
    end
    prev_hs = 0;
    if (m_valid && m_ready) begin
      if (beat_ptr_q.size() == 0) chk("unexpected_beat", 1'b1, 1'b0);
      else begin
        chk("beat_ptr", m_ptr, beat_ptr_q.pop_front());
        chk("beat_data", m_data, beat_dat_q.pop_front());
      end
      mdl_vld = 0;
      hs_cyc  = cyc;
      prev_hs = 1;
    end
    prev_vld = m_valid; prev_ptr = m_ptr; prev_dat = m_data;

    if (fifo_rd_en) begin rd_cnt++; rd_cyc.push_back(cyc); end
    rd_q  = fifo_rd_en;
    rst_q = reset;
    if (wait_now) begin
      if (rsp_ptr_q.size() == 0) chk("resp_underflow", 1'b1, 1'b0);
      else begin
        fifo_ptr  = rsp_ptr_q.pop_front();
        fifo_data = rsp_dat_q.pop_front();
      end
      pend_ptr = fifo_ptr; pend_dat = fifo_data; pend = 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge rd_clk); #2; end
  endtask

  task automatic push(input logic [31:0] p, input logic [WIDTH-1:0] d);
    rsp_ptr_q.push_back(p); rsp_dat_q.push_back(d);
  endtask

  // Open the FIFO until n more strobes are seen, then close it again
  task automatic do_reads(input int n);
    int tgt;
    tgt = rd_cnt + n;
    fifo_empty = 1'b0;
    for (int i = 0; i < 200 && rd_cnt < tgt; i++) step(1);
    if (rd_cnt < tgt) chk("read_timeout", 1'b1, 1'b0);
    fifo_empty = 1'b1;
  endtask

  initial begin
    int base;
    step(3);
    reset = 1'b0;
    step(20);
    chk("idle_rd_cnt", rd_cnt, 0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_m_ptr", m_ptr, 0);
    chk("idle_m_data", m_data, 0);

    // stale slot then three consecutive words
    push(63, 0); push(0, 512'hA); push(1, 512'hB); push(2, 512'hC);
    base = rd_cyc.size();
    do_reads(4);
    step(6);
    for (int i = 1; i < 4; i++) chk("rd_spacing", rd_cyc[base+i] - rd_cyc[base+i-1], 3);
    chk("p1_word", word_count, 3);
    chk("p1_dup", dup_count, 1);
    chk("p1_gap", gap_count, 0);
    chk("p1_m_ptr", m_ptr, 2);
    chk("p1_m_data", m_data, 512'hC);

    // repeat of slot 2, then a jump to 5
    push(2, 512'hD); push(5, 512'hE);
    do_reads(2);
    step(6);
    chk("p2_dup", dup_count, 2);
    chk("p2_gap", gap_count, 1);
    chk("p2_word", word_count, 4);
    chk("p2_m_ptr", m_ptr, 5);

    // jump to 63, then wrap to 0 without a gap
    push(63, 512'hF); push(0, 512'h10);
    do_reads(2);
    step(6);
    chk("p3_gap", gap_count, 2);
    chk("p3_word", word_count, 6);
    chk("p3_m_ptr", m_ptr, 0);

    // backpressure
    m_ready = 1'b0;
    push(1, 512'h11);
    do_reads(1);
    step(12);
    chk("bp_valid", m_valid, 1'b1);
    chk("bp_m_ptr", m_ptr, 1);
    chk("bp_m_data", m_data, 512'h11);
    base = rd_cnt;
    push(2, 512'h12);
    m_ready = 1'b1;
    do_reads(1);
    chk("bp_one_read", rd_cnt - base, 1);
    chk("bp_issue_after_hs", rd_cyc[rd_cyc.size()-1] - hs_cyc, 1);
    step(6);
    chk("bp_word", word_count, 8);

    // reset landing in WAIT
    push(3, 512'h13);
    base = rd_cnt + 1;
    fifo_empty = 1'b0;
    for (int i = 0; i < 200 && rd_cnt < base; i++) step(1);
    if (rd_cnt < base) chk("rst_read_timeout", 1'b1, 1'b0);
    reset = 1'b1; fifo_empty = 1'b1;
    step(1);
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_en", fifo_rd_en, 1'b0);
    chk("rst_word", word_count, 0);
    chk("rst_dup", dup_count, 0);
    chk("rst_gap", gap_count, 0);
    chk("rst_m_ptr", m_ptr, 0);
    chk("rst_m_data", m_data, 0);
    reset = 1'b0;
    step(2);
    push(63, 512'h14);
    do_reads(1);
    step(6);
    chk("post_rst_dup", dup_count, 1);
    chk("post_rst_word", word_count, 0);
    chk("beats_drained", beat_ptr_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fifo_track_monitor.md
# fifo_track_monitor

- Single-clock consumer that sits directly downstream of the circular overwrite FIFO, in its read-clock domain.
- Issues read strobes to the FIFO and captures the returned word and slot pointer.
- Discards repeated reads of the same slot; the FIFO returns the same slot again when the reader catches up with the writer.
- Presents each new word once on a valid/ready output port, and keeps counts of duplicates, pointer gaps and delivered words for debug.

## Interface
Parameters:
- DEPTH, 64, FIFO slot count; valid pointers are 0..DEPTH-1
- WIDTH, 512, data word width in bits

Ports:
- rd_clk  in  1  the block's single clock, same as the FIFO read clock
- reset  in  1  synchronous reset, active-high, sampled on rising rd_clk
- enable  in  1  level; when low, no new read is issued
- fifo_empty  in  1  FIFO empty flag, treated as a level in rd_clk
- fifo_rd_en  out  1  read strobe to the FIFO
- fifo_data  in  WIDTH  FIFO data_out
- fifo_ptr  in  32  FIFO slot pointer of fifo_data
- m_data  out  WIDTH  output word
- m_ptr  out  32  slot pointer of m_data
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- word_count  out  32  words delivered; saturating
- dup_count  out  32  reads discarded as duplicates; saturating
- gap_count  out  32  non-consecutive pointer events; saturating
- busy  out  1  high whenever state is not IDLE

## Operation
- State machine: IDLE, ISSUE, WAIT, OUT.
- Read condition: enable && !fifo_empty.
- IDLE: go to ISSUE if the read condition holds; otherwise stay.
- ISSUE: fifo_rd_en = 1 (combinational decode of state == ISSUE). Always go to WAIT.
- WAIT: fifo_data and fifo_ptr are valid this cycle and are sampled at its end. Then:
  - Duplicate (fifo_ptr == last_ptr): dup_count += 1, go to IDLE.
  - Otherwise:
    - Compute exp = (last_ptr == DEPTH-1) ? 0 : last_ptr + 1.
    - If fifo_ptr != exp, gap_count += 1.
    - Load m_data and m_ptr, set last_ptr = fifo_ptr, word_count += 1, set m_valid, go to OUT.
- OUT:
  - m_valid = 1; m_data and m_ptr are held stable.
  - On m_valid && m_ready: clear m_valid. Go to ISSUE if the read condition holds, else to IDLE.
  - Without m_ready: stay in OUT.
- Pointer comparisons use the full 32 bits. last_ptr is an internal 32-bit register.
- First read after reset: the FIFO returns its stale initial slot DEPTH-1. last_ptr resets to DEPTH-1, so this read is discarded and counted in dup_count. This is intended.
- At most one read is outstanding. fifo_rd_en is never high in two consecutive cycles.
- enable falling mid-transaction: the current ISSUE/WAIT/OUT sequence completes; no further read is issued.
- fifo_empty rising during WAIT or OUT does not affect the current word.
- Counters saturate at 32'hFFFF_FFFF.
- Reset (including mid-operation) has priority over everything:
  - state = IDLE, last_ptr = DEPTH-1.
  - m_valid = 0, m_data = 0, m_ptr = 0.
  - All counters = 0.
  - fifo_rd_en = 0, busy = 0.

## Timing
- Cycle 0 IDLE with the read condition true; cycle 1 ISSUE with fifo_rd_en high; cycle 2 WAIT; cycle 3 m_valid high.
- Latency from fifo_rd_en to m_valid: 2 cycles.
- Counters update at the end of WAIT and are visible in cycle 3.
- With m_ready held high and the FIFO never empty:
  - Back-to-back new words give one beat every 3 cycles (OUT → ISSUE → WAIT).
  - A duplicate read costs 3 cycles (ISSUE, WAIT, IDLE).
- m_valid, once high, stays high with m_data and m_ptr constant until the handshake edge.
- busy is registered state decode: high in ISSUE, WAIT and OUT.

## Test plan
- Reset, fifo_empty=1, enable=1 for 20 cycles -> fifo_rd_en stays 0, m_valid 0, all counters 0, busy 0.
- fifo_empty=0, first read returns ptr=63 (DEPTH=64) -> no beat, dup_count=1. Following reads return ptr 0, 1, 2 with data 0xA, 0xB, 0xC, m_ready=1 -> three beats (m_ptr 0, 1, 2), word_count=3, gap_count=0, fifo_rd_en pulses exactly 3 cycles apart.
- Repeated read returns ptr=2 again -> no beat, dup_count increments by 1. Next read returns ptr=5 -> beat emitted with m_ptr=5, gap_count=1.
- Pointer wrap: last_ptr=63, next read returns ptr=0 -> beat emitted, gap_count unchanged.
- m_ready=0 for 10 cycles while in OUT -> m_valid stays 1, m_data/m_ptr constant, fifo_rd_en stays 0. m_ready=1 -> handshake, and ISSUE follows on the next cycle if fifo_empty=0.
- reset asserted during WAIT -> next cycle all outputs and counters 0, state IDLE. A following read with ptr=63 counts as a duplicate (dup_count=1).
